clock_display_scan: RTL
=======================

Name: clock_display_scan

Overview:
- Sits directly downstream of the digital clock counters.
- Consumes binary SECOND/MINUTE/HOUR values and drives a 6-digit multiplexed seven-segment display in HH:MM:SS format.
- Snapshots the time once per scan frame, converts each field to two BCD digits and time-multiplexes them onto one segment bus with one-hot digit selects.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit is held; minimum 2. Benches use 4.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- SECOND  in  6  binary seconds from the clock counters.
- MINUTE  in  6  binary minutes from the clock counters.
- HOUR  in  4  binary hours from the clock counters.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- dp  out  1  decimal point/colon, active-high.
- an  out  6  one-hot digit enable, active-high; bit 0 = seconds ones, bit 5 = hour tens.
- frame  out  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; prescaler=0; digit_idx=5; snapshot registers=0.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick=1 when prescaler==SCAN_DIV-1.
- On tick, digit_idx advances: 0->1->...->5->0. The first tick after reset moves 5->0.
- Snapshot: on the tick where digit_idx goes 5->0, SECOND/MINUTE/HOUR are latched into snapshot registers and frame pulses high in the following cycle.
  - All six digits of a frame therefore come from one coherent time value.
  - Input changes mid-frame are not visible until the next frame.
- Outputs are registered:
  - seg/an/dp reflect the new digit_idx in the cycle after tick.
  - The first digit (an=6'b000001) appears SCAN_DIV+1 cycles after reset deasserts.
  - Until then an=0, seg=0 and dp=0.
- Digit mapping:
  - idx0 = sec ones, idx1 = sec tens
  - idx2 = min ones, idx3 = min tens
  - idx4 = hour ones, idx5 = hour tens
- BCD conversion: tens = v/10, ones = v%10.
  - SECOND/MINUTE values 60..63 are out of range and show a dash (7'h40) on both digits of that field.
  - HOUR 0..15 is shown as decimal.
  - Hour tens digit = 0 is blanked (seg=0), but an still asserts.
- Segment codes:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - dash=40, blank=00
- dp: asserted on idx2 and idx4 (colon positions) only when snapshot SECOND[0]==0, giving a 1 Hz blink. 0 otherwise.
- an is always exactly one-hot after the first tick. No overlap and no gap cycles between digits.
- Reset mid-frame: immediate return to reset state. The partial frame is discarded and no frame pulse is generated.

Decomposition:
- Package clock_disp_pkg holds:
  - the seven-segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK
  - digit index localparams DIG_SEC_ONES..DIG_HR_TENS
  - the digit count (6)
- One combinational sub-module, clock_bin2bcd: 6-bit binary in -> tens[3:0], ones[3:0], valid (v<=59 for the sec/min range check). Instantiated three times; HOUR is zero-extended.
- Prescaler, index counter, snapshot registers and output registers live in the top module.

Test Plan:
1. Reset, then release with SCAN_DIV=4 and inputs 12:34:56.
   - Required: an=0 for 5 cycles.
   - Required: then an=000001 with seg=7D ('6'), and frame pulses once.
   - Required: subsequent digits 5,4,3,2,1 on seg at a 4-cycle spacing.
2. Inputs 09:05:07.
   - Required: idx5 seg=00 (blanked) with an[5]=1.
   - Required: idx4 seg=6F, idx3 seg=3F, idx2 seg=6D.
   - Required: dp=0 on idx2/idx4, because SECOND=7 is odd.
3. Change SECOND 10->11 while idx=2.
   - Required: remaining digits of that frame still show from 10.
   - Required: the next frame shows 11, and dp goes 1->0 at idx2.
4. Apply MINUTE=62.
   - Required: idx2 and idx3 show seg=40; the other fields are unaffected.
5. Assert reset while idx=3.
   - Required: an, seg, dp and frame go to 0 asynchronously, with no frame pulse.
   - Required: after release, the scan restarts at idx0 after SCAN_DIV+1 cycles.
6. Run 3 full frames.
   - Required: frame pulses exactly every 6*SCAN_DIV cycles.
   - Required: an is one-hot on every cycle after the first digit appears.

Source files
------------

// File: rtl/clock_disp_pkg.sv
`default_nettype none
// ============================================================================
// clock_disp_pkg : segment codes, digit positions and decode helper for the
//                  HH:MM:SS scan display.                       Revision: 1.0
// ============================================================================
package clock_disp_pkg;

  localparam int NUM_DIGITS = 6;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [2:0] DIG_SEC_ONES = 3'd0;
  localparam logic [2:0] DIG_SEC_TENS = 3'd1;
  localparam logic [2:0] DIG_MIN_ONES = 3'd2;
  localparam logic [2:0] DIG_MIN_TENS = 3'd3;
  localparam logic [2:0] DIG_HR_ONES  = 3'd4;
  localparam logic [2:0] DIG_HR_TENS  = 3'd5;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_bin2bcd.sv
`default_nettype none
// ============================================================================
// clock_bin2bcd : 6-bit binary to two BCD digits with 0..59 range flag.
//                                                               Revision: 1.0
// ============================================================================
module clock_bin2bcd (
  input  logic [5:0] v,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       valid
);

  // Compare chain instead of a divider; the input never exceeds 63
  always_comb begin
    tens = 4'd0;
    ones = 4'(v);
    if (v >= 6'd60) begin
      tens = 4'd6;
      ones = 4'(v - 6'd60);
    end else if (v >= 6'd50) begin
      tens = 4'd5;
      ones = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      tens = 4'd4;
      ones = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      tens = 4'd3;
      ones = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      tens = 4'd2;
      ones = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      tens = 4'd1;
      ones = 4'(v - 6'd10);
    end
    valid = (v <= 6'd59);
  end

endmodule
`default_nettype wire

// File: rtl/clock_display_scan.sv
`default_nettype none
// ============================================================================
// clock_display_scan : snapshots HH:MM:SS once per frame and scans it onto a
//                      6-digit multiplexed seven-segment display. Revision: 1.0
// ============================================================================
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] SECOND,
  input  logic [5:0] MINUTE,
  input  logic [3:0] HOUR,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] c_presc_max = PW'(SCAN_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_digit_idx;
  logic          r_started;
  logic [5:0]    r_snap_sec;
  logic [5:0]    r_snap_min;
  logic [3:0]    r_snap_hr;
  logic [6:0]    r_seg;
  logic [5:0]    r_an;
  logic          r_dp;
  logic          r_frame;

  logic          w_tick;
  logic          w_frame_start;
  logic [3:0]    w_sec_tens, w_sec_ones, w_min_tens, w_min_ones;
  logic [3:0]    w_hr_tens, w_hr_ones;
  logic          w_sec_valid, w_min_valid, w_hr_valid;
  logic [6:0]    w_seg;
  logic [5:0]    w_an;
  logic          w_dp;

  assign w_tick        = (r_presc == c_presc_max);
  assign w_frame_start = w_tick && (r_digit_idx == DIG_HR_TENS);

  clock_bin2bcd u_sec (.v(r_snap_sec), .tens(w_sec_tens), .ones(w_sec_ones), .valid(w_sec_valid));
  clock_bin2bcd u_min (.v(r_snap_min), .tens(w_min_tens), .ones(w_min_ones), .valid(w_min_valid));
  clock_bin2bcd u_hr  (.v({2'b00, r_snap_hr}), .tens(w_hr_tens), .ones(w_hr_ones), .valid(w_hr_valid));

  always_comb begin
    w_seg = SEG_BLANK;
    w_dp  = 1'b0;
    w_an  = NUM_DIGITS'(1) << r_digit_idx;
    case (r_digit_idx)
      DIG_SEC_ONES: w_seg = w_sec_valid ? seg_decode(w_sec_ones) : SEG_DASH;
      DIG_SEC_TENS: w_seg = w_sec_valid ? seg_decode(w_sec_tens) : SEG_DASH;
      DIG_MIN_ONES: begin
        w_seg = w_min_valid ? seg_decode(w_min_ones) : SEG_DASH;
        w_dp  = ~r_snap_sec[0];
      end
      DIG_MIN_TENS: w_seg = w_min_valid ? seg_decode(w_min_tens) : SEG_DASH;
      DIG_HR_ONES: begin
        w_seg = w_hr_valid ? seg_decode(w_hr_ones) : SEG_DASH;
        w_dp  = ~r_snap_sec[0];
      end
      DIG_HR_TENS: begin
        // Leading hour zero stays dark while its digit slot is still scanned
        if (!w_hr_valid)
          w_seg = SEG_DASH;
        else if (w_hr_tens == 4'd0)
          w_seg = SEG_BLANK;
        else
          w_seg = seg_decode(w_hr_tens);
      end
      default: w_an = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_presc     <= '0;
      r_digit_idx <= DIG_HR_TENS;
      r_started   <= 1'b0;
      r_snap_sec  <= '0;
      r_snap_min  <= '0;
      r_snap_hr   <= '0;
      r_seg       <= '0;
      r_an        <= '0;
      r_dp        <= 1'b0;
      r_frame     <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_digit_idx <= (r_digit_idx == DIG_HR_TENS) ? DIG_SEC_ONES : r_digit_idx + 3'd1;
        r_started   <= 1'b1;
      end
      if (w_frame_start) begin
        r_snap_sec <= SECOND;
        r_snap_min <= MINUTE;
        r_snap_hr  <= HOUR;
      end
      r_frame <= w_frame_start;
      // Display stays dark until the first tick has selected digit 0
      r_seg   <= r_started ? w_seg : '0;
      r_an    <= r_started ? w_an  : '0;
      r_dp    <= r_started ? w_dp  : 1'b0;
    end
  end

  assign seg   = r_seg;
  assign an    = r_an;
  assign dp    = r_dp;
  assign frame = r_frame;

endmodule
`default_nettype wire
